// File: rtl/arith_pkg.sv
// Shared helpers for the multi-cycle arithmetic blocks.
// Chunk geometry and the combinational ready-chain depth limit.
package arith_pkg;

  localparam int MAX_ARITH_LATENCY = 8;

  function automatic int chunk_lo(
    input int k,
    input int width,
    input int latency
  );
    return k * (width / latency);
  endfunction

  // The last chunk absorbs the remainder bits.
  function automatic int chunk_width(
    input int k,
    input int width,
    input int latency
  );
    int base;
    base = width / latency;
    if (k < latency - 1) begin
      return base;
    end
    return width - (latency - 1) * base;
  endfunction

endpackage

// File: rtl/pipelined_subtractor_stage.sv
// One pipeline slot: register, chunk subtraction, load/hold.
// Ports: clock/reset, load, in_* (upstream), registered outputs.
module pipelined_subtractor_stage
  import arith_pkg::*;
#(
  parameter int width = 32,
  parameter int lo = 0,
  parameter int cw = 32,
  parameter type metadata_type = logic,
  parameter metadata_type default_metadata = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             in_valid,
  input  logic [width-1:0] in_lhs,
  input  logic [width-1:0] in_rhs,
  input  logic [width-1:0] in_res,
  input  logic             in_borrow,
  input  metadata_type     in_meta,
  output logic             valid,
  output logic [width-1:0] lhs,
  output logic [width-1:0] rhs,
  output logic [width-1:0] res,
  output logic             borrow,
  output metadata_type     meta
);

  logic [cw-1:0]    a;
  logic [cw-1:0]    b;
  logic [cw-1:0]    d;
  logic             c;
  logic [width-1:0] part;

  assign a = in_lhs[lo +: cw];
  assign b = in_rhs[lo +: cw];

  // a - b - borrow == a + ~b + !borrow; carry-out low means borrow.
  assign {c, d} = {1'b0, a}
                + {1'b0, ~b}
                + {{cw{1'b0}}, ~in_borrow};

  always_comb begin
    part = '0;
    part[lo +: cw] = d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid  <= 1'b0;
      lhs    <= '0;
      rhs    <= '0;
      res    <= '0;
      borrow <= 1'b0;
      meta   <= default_metadata;
    end else if (load) begin
      valid  <= in_valid;
      lhs    <= in_lhs;
      rhs    <= in_rhs;
      res    <= in_res | part;
      borrow <= ~c;
      meta   <= in_meta;
    end
  end

endmodule

// File: rtl/pipelined_subtractor.sv
// Streaming res = lhs - rhs - iborrow, chunked over latency stages.
// Ports: clock/reset, ivalid/iready/imeta/lhs/rhs/iborrow in,
//        ovalid/oready/ometa/res/oborrow/ozero/ooverflow out.
module pipelined_subtractor
  import arith_pkg::*;
#(
  parameter int width = 32,
  parameter int latency = 2,
  parameter type metadata_type = logic,
  parameter metadata_type default_metadata = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ivalid,
  output logic             iready,
  input  metadata_type     imeta,
  input  logic [width-1:0] lhs,
  input  logic [width-1:0] rhs,
  input  logic             iborrow,
  output logic             ovalid,
  input  logic             oready,
  output metadata_type     ometa,
  output logic [width-1:0] res,
  output logic             oborrow,
  output logic             ozero,
  output logic             ooverflow
);

  localparam int L = latency - 1;

  logic [latency-1:0] valid;
  logic [latency:0]   load;
  logic [width-1:0]   lhs_q [latency];
  logic [width-1:0]   rhs_q [latency];
  logic [width-1:0]   res_q [latency];
  logic [latency-1:0] borrow_q;
  metadata_type       meta_q [latency];

  // A slot may load when it is empty or its successor moves,
  // which lets bubbles collapse under a stalled output.
  assign load[latency] = oready;
  assign iready = load[0] && !reset;

  for (genvar k = 0; k < latency; k++) begin : g_stage
    logic             in_valid;
    logic [width-1:0] in_lhs;
    logic [width-1:0] in_rhs;
    logic [width-1:0] in_res;
    logic             in_borrow;
    metadata_type     in_meta;

    assign load[k] = !valid[k] || load[k+1];

    if (k == 0) begin : g_head
      assign in_valid  = ivalid && iready;
      assign in_lhs    = lhs;
      assign in_rhs    = rhs;
      assign in_res    = '0;
      assign in_borrow = iborrow;
      assign in_meta   = imeta;
    end else begin : g_body
      assign in_valid  = valid[k-1];
      assign in_lhs    = lhs_q[k-1];
      assign in_rhs    = rhs_q[k-1];
      assign in_res    = res_q[k-1];
      assign in_borrow = borrow_q[k-1];
      assign in_meta   = meta_q[k-1];
    end

    pipelined_subtractor_stage #(
      .width           (width),
      .lo              (chunk_lo(k, width, latency)),
      .cw              (chunk_width(k, width, latency)),
      .metadata_type   (metadata_type),
      .default_metadata(default_metadata)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .load     (load[k]),
      .in_valid (in_valid),
      .in_lhs   (in_lhs),
      .in_rhs   (in_rhs),
      .in_res   (in_res),
      .in_borrow(in_borrow),
      .in_meta  (in_meta),
      .valid    (valid[k]),
      .lhs      (lhs_q[k]),
      .rhs      (rhs_q[k]),
      .res      (res_q[k]),
      .borrow   (borrow_q[k]),
      .meta     (meta_q[k])
    );
  end

  logic [width-1:0] fin;
  logic             lmsb;
  logic             rmsb;

  assign fin  = res_q[L];
  assign lmsb = lhs_q[L][width-1];
  assign rmsb = rhs_q[L][width-1];

  // Outputs are forced quiet during reset, before the
  // registers have taken their cleared values.
  assign ovalid    = valid[L] && !reset;
  assign res       = reset ? '0 : fin;
  assign oborrow   = !reset && borrow_q[L];
  assign ozero     = !reset && (fin == '0);
  assign ooverflow = !reset && (lmsb != rmsb)
                  && (fin[width-1] != lmsb);
  assign ometa     = reset ? default_metadata : meta_q[L];

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Bench for pipelined_subtractor at three width/latency points.
// Random and directed ops checked against an arithmetic model.
module tb_pipelined_subtractor;

  localparam logic [7:0] DM = 8'hA5;

  typedef struct {
    logic [31:0] res;
    logic        b;
    logic        z;
    logic        o;
    logic [7:0]  m;
    int          t;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit lat_en = 1'b0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  logic        reset_a, ivalid_a, iready_a, iborrow_a;
  logic        ovalid_a, oready_a, oborrow_a, ozero_a, ooverflow_a;
  logic [7:0]  imeta_a, ometa_a;
  logic [31:0] lhs_a, rhs_a, res_a;

  logic        reset_b, ivalid_b, iready_b, iborrow_b;
  logic        ovalid_b, oready_b, oborrow_b, ozero_b, ooverflow_b;
  logic [7:0]  imeta_b, ometa_b;
  logic [9:0]  lhs_b, rhs_b, res_b;

  logic        reset_c, ivalid_c, iready_c, iborrow_c;
  logic        ovalid_c, oready_c, oborrow_c, ozero_c, ooverflow_c;
  logic [7:0]  imeta_c, ometa_c;
  logic [15:0] lhs_c, rhs_c, res_c;

  pipelined_subtractor #(
    .width(32), .latency(2),
    .metadata_type(logic [7:0]), .default_metadata(DM)
  ) dut_a (
    .clock(clock), .reset(reset_a),
    .ivalid(ivalid_a), .iready(iready_a), .imeta(imeta_a),
    .lhs(lhs_a), .rhs(rhs_a), .iborrow(iborrow_a),
    .ovalid(ovalid_a), .oready(oready_a), .ometa(ometa_a),
    .res(res_a), .oborrow(oborrow_a), .ozero(ozero_a),
    .ooverflow(ooverflow_a)
  );

  pipelined_subtractor #(
    .width(10), .latency(3),
    .metadata_type(logic [7:0]), .default_metadata(DM)
  ) dut_b (
    .clock(clock), .reset(reset_b),
    .ivalid(ivalid_b), .iready(iready_b), .imeta(imeta_b),
    .lhs(lhs_b), .rhs(rhs_b), .iborrow(iborrow_b),
    .ovalid(ovalid_b), .oready(oready_b), .ometa(ometa_b),
    .res(res_b), .oborrow(oborrow_b), .ozero(ozero_b),
    .ooverflow(ooverflow_b)
  );

  pipelined_subtractor #(
    .width(16), .latency(4),
    .metadata_type(logic [7:0]), .default_metadata(DM)
  ) dut_c (
    .clock(clock), .reset(reset_c),
    .ivalid(ivalid_c), .iready(iready_c), .imeta(imeta_c),
    .lhs(lhs_c), .rhs(rhs_c), .iborrow(iborrow_c),
    .ovalid(ovalid_c), .oready(oready_c), .ometa(ometa_c),
    .res(res_c), .oborrow(oborrow_c), .ozero(ozero_c),
    .ooverflow(ooverflow_c)
  );

  // Reference: integer arithmetic on the w-bit operand values.
  function automatic exp_t model(
    input int w,
    input logic [31:0] l,
    input logic [31:0] r,
    input logic ib,
    input logic [7:0] m
  );
    exp_t e;
    longint full, half, lu, ru, d, ls, rs, ds;
    full = longint'(1) << w;
    half = full / 2;
    lu = longint'(l) & (full - 1);
    ru = longint'(r) & (full - 1);
    d = lu - ru - longint'(ib);
    e.res = 32'(d & (full - 1));
    e.b = (lu < ru + longint'(ib));
    e.z = (e.res == 32'd0);
    ls = (lu >= half) ? lu - full : lu;
    rs = (ru >= half) ? ru - full : ru;
    ds = ls - rs - longint'(ib);
    e.o = (ds < -half) || (ds >= half);
    e.m = m;
    e.t = 0;
    return e;
  endfunction

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] want
  );
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic cmp_out(
    input string tag,
    input exp_t e,
    input logic [31:0] r,
    input logic b,
    input logic z,
    input logic o,
    input logic [7:0] m,
    input int lat
  );
    chk({tag, ".res"}, 64'(r), 64'(e.res));
    chk({tag, ".borrow"}, 64'(b), 64'(e.b));
    chk({tag, ".zero"}, 64'(z), 64'(e.z));
    chk({tag, ".ovf"}, 64'(o), 64'(e.o));
    chk({tag, ".meta"}, 64'(m), 64'(e.m));
    if (lat_en) chk({tag, ".lat"}, 64'(cyc - e.t), 64'(lat));
  endtask

  task automatic step_a(
    input logic v, input logic [31:0] l, input logic [31:0] r,
    input logic ib, input logic [7:0] m, input logic ordy,
    output bit acc
  );
    exp_t e;
    ivalid_a = v; lhs_a = l; rhs_a = r;
    iborrow_a = ib; imeta_a = m; oready_a = ordy;
    #1;
    acc = v && iready_a;
    if (ovalid_a && oready_a) begin
      if (qa.size() == 0) chk("a.stale", 64'(ovalid_a), 0);
      else begin
        e = qa.pop_front();
        cmp_out("a", e, res_a, oborrow_a, ozero_a,
                ooverflow_a, ometa_a, 2);
      end
    end
    if (acc) begin
      e = model(32, l, r, ib, m);
      e.t = cyc;
      qa.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic step_b(
    input logic v, input logic [31:0] l, input logic [31:0] r,
    input logic ib, input logic [7:0] m, input logic ordy,
    output bit acc
  );
    exp_t e;
    ivalid_b = v; lhs_b = l[9:0]; rhs_b = r[9:0];
    iborrow_b = ib; imeta_b = m; oready_b = ordy;
    #1;
    acc = v && iready_b;
    if (ovalid_b && oready_b) begin
      if (qb.size() == 0) chk("b.stale", 64'(ovalid_b), 0);
      else begin
        e = qb.pop_front();
        cmp_out("b", e, 32'(res_b), oborrow_b, ozero_b,
                ooverflow_b, ometa_b, 3);
      end
    end
    if (acc) begin
      e = model(10, l, r, ib, m);
      e.t = cyc;
      qb.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic step_c(
    input logic v, input logic [31:0] l, input logic [31:0] r,
    input logic ib, input logic [7:0] m, input logic ordy,
    output bit acc
  );
    exp_t e;
    ivalid_c = v; lhs_c = l[15:0]; rhs_c = r[15:0];
    iborrow_c = ib; imeta_c = m; oready_c = ordy;
    #1;
    acc = v && iready_c;
    if (ovalid_c && oready_c) begin
      if (qc.size() == 0) chk("c.stale", 64'(ovalid_c), 0);
      else begin
        e = qc.pop_front();
        cmp_out("c", e, 32'(res_c), oborrow_c, ozero_c,
                ooverflow_c, ometa_c, 4);
      end
    end
    if (acc) begin
      e = model(16, l, r, ib, m);
      e.t = cyc;
      qc.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    int j;
    logic [31:0] l, r;
    logic ib;

    {ivalid_a, iborrow_a, oready_a} = '0;
    {ivalid_b, iborrow_b, oready_b} = '0;
    {ivalid_c, iborrow_c, oready_c} = '0;
    lhs_a = '0; rhs_a = '0; imeta_a = '0;
    lhs_b = '0; rhs_b = '0; imeta_b = '0;
    lhs_c = '0; rhs_c = '0; imeta_c = '0;
    reset_a = 1; reset_b = 1; reset_c = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    ivalid_a = 1; oready_a = 1;
    #1;
    chk("rst.ovalid", 64'(ovalid_a), 0);
    chk("rst.iready", 64'(iready_a), 0);
    chk("rst.res", 64'(res_a), 0);
    chk("rst.flags", 64'({oborrow_a, ozero_a, ooverflow_a}), 0);
    chk("rst.ometa", 64'(ometa_a), 64'(DM));
    chk("rst.ometa_c", 64'(ometa_c), 64'(DM));
    reset_a = 0; reset_b = 0; reset_c = 0;

    // Directed ops, back to back, with latency tracking.
    lat_en = 1;
    step_a(1, 32'h5, 32'h3, 0, 8'h01, 1, acc);
    chk("t1.acc", 64'(acc), 1);
    step_a(1, 32'h0001_0000, 32'h1, 0, 8'h02, 1, acc);
    step_a(1, 32'h0, 32'h0, 1, 8'h03, 1, acc);
    step_a(1, 32'h8000_0000, 32'h1, 0, 8'h04, 1, acc);
    step_a(1, 32'h1234_5678, 32'h1234_5678, 0, 8'h05, 1, acc);
    step_a(1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 8'h06, 1, acc);
    for (int i = 0; i < 10 && qa.size() != 0; i++)
      step_a(0, 0, 0, 0, 0, 1, acc);
    chk("a.drain", 64'(qa.size()), 0);

    // Uneven chunks with random stalls.
    lat_en = 0;
    for (int i = 0; i < 256; i++) begin
      case (i)
        0: begin l = 0; r = 0; ib = 0; end
        1: begin l = 0; r = 32'h3FF; ib = 1; end
        2: begin l = 32'h3FF; r = 0; ib = 0; end
        3: begin l = 32'h3FF; r = 32'h3FF; ib = 1; end
        4: begin l = 32'h200; r = 32'h1; ib = 0; end
        default: begin
          l = $urandom; r = $urandom; ib = 1'($urandom_range(0, 1));
        end
      endcase
      acc = 0;
      for (int t = 0; t < 40 && !acc; t++)
        step_b(1, l, r, ib, 8'(i), $urandom_range(0, 3) != 0, acc);
      if (!acc) chk("b.accept", 64'(acc), 1);
    end
    for (int i = 0; i < 20 && qb.size() != 0; i++)
      step_b(0, 0, 0, 0, 0, 1, acc);
    chk("b.drain", 64'(qb.size()), 0);

    // Backpressure fill: bubbles collapse until all 4 slots full.
    n = 0;
    j = 0;
    for (int i = 0; i < 8; i++) begin
      step_c(1, 32'(j * 1234 + 7), 32'(j * 4321 + 99), 1'(j),
             8'h40 + 8'(j), 0, acc);
      if (acc) begin n++; j++; end
    end
    chk("t5.accepted", 64'(n), 4);
    oready_c = 0;
    ivalid_c = 1;
    #1;
    chk("t5.iready", 64'(iready_c), 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5.ovalid", 64'(ovalid_c), 1);
      chk("t5.hold_res", 64'(res_c), 64'(qc[0].res));
      chk("t5.hold_meta", 64'(ometa_c), 64'(qc[0].m));
      chk("t5.hold_bor", 64'(oborrow_c), 64'(qc[0].b));
      step_c(1, 32'(j * 1234 + 7), 32'(j * 4321 + 99), 1'(j),
             8'h40 + 8'(j), 0, acc);
    end
    step_c(1, 32'(j * 1234 + 7), 32'(j * 4321 + 99), 1'(j),
           8'h40 + 8'(j), 1, acc);
    chk("t5.same_edge", 64'(acc), 1);
    j++;
    oready_c = 0;
    #1;
    chk("t5.refull", 64'(iready_c), 0);
    for (int i = 0; i < 20 && qc.size() != 0; i++)
      step_c(0, 0, 0, 0, 0, 1, acc);
    chk("c.drain", 64'(qc.size()), 0);

    // Reset with three ops in flight.
    lat_en = 1;
    for (int i = 0; i < 3; i++)
      step_b(1, $urandom, $urandom, 0, 8'h80 + 8'(i), 0, acc);
    chk("t6.full", 64'(ovalid_b), 1);
    reset_b = 1;
    ivalid_b = 1;
    oready_b = 1;
    #1;
    chk("t6.ovalid", 64'(ovalid_b), 0);
    chk("t6.iready", 64'(iready_b), 0);
    chk("t6.ometa", 64'(ometa_b), 64'(DM));
    chk("t6.res", 64'(res_b), 0);
    @(posedge clock);
    @(negedge clock);
    cyc++;
    reset_b = 0;
    qb.delete();
    for (int i = 0; i < 5; i++) begin
      step_b(0, 0, 0, 0, 0, 1, acc);
      chk("t6.idle", 64'(ovalid_b), 0);
    end
    step_b(1, 32'h155, 32'h2AA, 1, 8'h99, 1, acc);
    chk("t6.acc", 64'(acc), 1);
    for (int i = 0; i < 10 && qb.size() != 0; i++)
      step_b(0, 0, 0, 0, 0, 1, acc);
    chk("t6.drain", 64'(qb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
